mbist_march_engine: RTL and testbench

March C- memory BIST engine that drives the embedded SRAM test port and streams failing addresses to the repair controller. On `start` it walks the main array (address 0 to `LAST_ADDR`) through six March elements, compares every read against its expected background, and pulses `fail_valid`/`fail_addr` once per mismatching read. It is the producer side of the fail-report interface: `fail_valid`/`fail_addr` connect directly to the repair controller's `bist_fail_valid`/`bist_fail_addr`.

---
 rtl/mbist_march_engine.sv | 156 +++++++++++++++
 tb/tb_mbist_march_engine.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mbist_march_engine.sv
// March C- BIST engine: walks the test port through six March elements and
// streams every mismatching read out as a one-cycle fail report.
module mbist_march_engine #(
  parameter int                    ADDR_WIDTH = 5,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] LAST_ADDR  = 5'h1D,
  parameter int                    FCNT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_en,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  fail_valid,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_syndrome,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [FCNT_WIDTH-1:0] fail_count
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  typedef enum logic [2:0] {M0, M1, M2, M3, M4, M5} elem_t;

  state_t                state, state_n;
  elem_t                 elem, elem_n;
  logic [ADDR_WIDTH-1:0] addr, addr_n;
  logic                  phase, phase_n;
  logic                  drain_cnt, drain_cnt_n;
  logic                  launch;

  logic                  two_op, descending, is_read, addr_end;
  logic [DATA_WIDTH-1:0] wr_bg, rd_bg;

  logic                  pend_valid;
  logic [ADDR_WIDTH-1:0] pend_addr;
  logic [DATA_WIDTH-1:0] pend_exp;
  logic                  mismatch;

  // Element attributes: M1..M4 are read-then-write pairs; phase 0 is the read.
  always_comb begin
    two_op     = (elem != M0) && (elem != M5);
    descending = (elem == M3) || (elem == M4);
    wr_bg      = (elem == M1 || elem == M3) ? '1 : '0;
    rd_bg      = (elem == M2 || elem == M4) ? '1 : '0;
    is_read    = (elem == M5) || (two_op && !phase);
    addr_end   = descending ? (addr == '0) : (addr == LAST_ADDR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      elem      <= M0;
      addr      <= '0;
      phase     <= 1'b0;
      drain_cnt <= 1'b0;
    end else begin
      state     <= state_n;
      elem      <= elem_n;
      addr      <= addr_n;
      phase     <= phase_n;
      drain_cnt <= drain_cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    elem_n      = elem;
    addr_n      = addr;
    phase_n     = phase;
    drain_cnt_n = drain_cnt;
    launch      = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          launch  = 1'b1;
          state_n = RUN;
          elem_n  = M0;
          addr_n  = '0;
          phase_n = 1'b0;
        end
      end
      RUN: begin
        if (two_op && !phase) begin
          phase_n = 1'b1;
        end else begin
          phase_n = 1'b0;
          if (!addr_end) begin
            addr_n = descending ? addr - 1'b1 : addr + 1'b1;
          end else begin
            // Each new element starts at the far end for its direction.
            case (elem)
              M0: begin elem_n = M1; addr_n = '0;        end
              M1: begin elem_n = M2; addr_n = '0;        end
              M2: begin elem_n = M3; addr_n = LAST_ADDR; end
              M3: begin elem_n = M4; addr_n = LAST_ADDR; end
              M4: begin elem_n = M5; addr_n = '0;        end
              default: begin
                state_n     = DRAIN;
                addr_n      = '0;
                drain_cnt_n = 1'b0;
              end
            endcase
          end
        end
      end
      DRAIN: begin
        if (drain_cnt) state_n = DONE;
        else drain_cnt_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    mem_en    = (state == RUN);
    mem_we    = (state == RUN) && !is_read;
    mem_addr  = (state == RUN) ? addr : '0;
    mem_wdata = (state == RUN) ? wr_bg : '0;
    busy      = (state == RUN) || (state == DRAIN);
    done      = (state == DONE);
    pass      = (state == DONE) && (fail_count == '0);
  end

  assign mismatch = pend_valid && (mem_rdata != pend_exp);

  // Read data arrives one cycle after the command, so the expectation is
  // parked for a cycle and the fail report is registered one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid    <= 1'b0;
      pend_addr     <= '0;
      pend_exp      <= '0;
      fail_valid    <= 1'b0;
      fail_addr     <= '0;
      fail_syndrome <= '0;
      fail_count    <= '0;
    end else begin
      pend_valid <= (state == RUN) && is_read;
      pend_addr  <= addr;
      pend_exp   <= rd_bg;
      fail_valid <= mismatch;
      if (mismatch) begin
        fail_addr     <= pend_addr;
        fail_syndrome <= mem_rdata ^ pend_exp;
      end
      if (launch) fail_count <= '0;
      else if (mismatch && fail_count != '1) fail_count <= fail_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_mbist_march_engine.sv
// Scoreboard bench for mbist_march_engine: a March C- reference model fills
// command and fail queues; a negedge monitor pops and compares them.
module tb_mbist_march_engine;

  localparam int AW    = 5;
  localparam int DW    = 8;
  localparam int FW    = 8;
  localparam int N     = 30;
  localparam int LAST  = 29;
  localparam int TOTAL = 10 * N;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic          mem_en;
  logic [DW-1:0] mem_rdata = '0;
  logic          fail_valid;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_syndrome;
  logic          busy;
  logic          done;
  logic          pass;
  logic [FW-1:0] fail_count;

  always #5 clk = ~clk;

  mbist_march_engine dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mem_en       (mem_en),
    .mem_rdata    (mem_rdata),
    .fail_valid   (fail_valid),
    .fail_addr    (fail_addr),
    .fail_syndrome(fail_syndrome),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .fail_count   (fail_count)
  );

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] data;
  } cmd_t;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] syn;
  } fail_t;

  cmd_t  cmd_q[$];
  fail_t fail_q[$];

  logic [DW-1:0] mem [32];
  logic [DW-1:0] sa0 [32];
  logic [DW-1:0] sa1 [32];

  int edge_cnt   = 0;
  int start_edge = 0;
  int vectors    = 0;
  int miscompares = 0;
  int exp_fails  = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Synchronous-read SRAM with stuck-at faults applied on the read path.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else mem_rdata <= (mem[mem_addr] & ~sa0[mem_addr]) | sa1[mem_addr];
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_faults();
    for (int i = 0; i < 32; i++) begin
      sa0[i] = '0;
      sa1[i] = '0;
      mem[i] = '0;
    end
  endtask

  // Reference: walk the March C- elements over an ideal memory image.
  task automatic build_model();
    logic [DW-1:0] img [32];
    logic [AW-1:0] a;
    logic [DW-1:0] wbg, rbg, act;
    bit rd, wr, down;
    int c;
    c = 0;
    exp_fails = 0;
    for (int i = 0; i < 32; i++) img[i] = '0;
    for (int e = 0; e < 6; e++) begin
      rd   = (e != 0);
      wr   = (e != 5);
      down = (e == 3 || e == 4);
      wbg  = (e == 1 || e == 3) ? 8'hFF : 8'h00;
      rbg  = (e == 2 || e == 4) ? 8'hFF : 8'h00;
      for (int i = 0; i < N; i++) begin
        a = down ? AW'(LAST - i) : AW'(i);
        if (rd) begin
          cmd_q.push_back('{c, a, 1'b0, wbg});
          act = (img[a] & ~sa0[a]) | sa1[a];
          if (act != rbg) begin
            fail_q.push_back('{c + 2, a, act ^ rbg});
            exp_fails++;
          end
          c++;
        end
        if (wr) begin
          img[a] = wbg;
          cmd_q.push_back('{c, a, 1'b1, wbg});
          c++;
        end
      end
    end
    if (exp_fails > 255) exp_fails = 255;
  endtask

  // Called in the #1-after-edge phase; leaves the bench in that phase.
  task automatic applyStimulus(input bit hold);
    start = 1'b1;
    @(posedge clk);
    #1;
    start_edge = edge_cnt;
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_rel(input int r);
    int guard;
    guard = 0;
    while ((edge_cnt - start_edge) < r && guard < 2000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 2000) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL wait_rel timeout: got cycle %0d, expected %0d", edge_cnt - start_edge, r);
    end
  endtask

  task automatic run_full(input string name);
    build_model();
    applyStimulus(1'b0);
    wait_rel(TOTAL + 1);
    checkOutput({name, " busy in drain"}, 64'(busy), 64'd1);
    checkOutput({name, " done in drain"}, 64'(done), 64'd0);
    wait_rel(TOTAL + 2);
    checkOutput({name, " busy at end"}, 64'(busy), 64'd0);
    checkOutput({name, " done at end"}, 64'(done), 64'd1);
    checkOutput({name, " pass"}, 64'(pass), 64'(exp_fails == 0));
    checkOutput({name, " fail_count"}, 64'(fail_count), 64'(exp_fails));
    checkOutput({name, " leftover expectations"}, 64'(cmd_q.size() + fail_q.size()), 64'd0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a command or fail.
  always @(negedge clk) begin
    int    rel;
    cmd_t  ec;
    fail_t ef;
    if (!rst) begin
      rel = edge_cnt - start_edge;
      if (mem_en) begin
        if (cmd_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL extra command: got addr %0h we %0b at cycle %0d, expected none", mem_addr, mem_we, rel);
        end else begin
          ec = cmd_q.pop_front();
          checkOutput("command {cycle,addr,we,wdata}",
                      {32'(rel), 8'(mem_addr), 8'(mem_we), mem_wdata},
                      {32'(ec.cyc), 8'(ec.addr), 8'(ec.we), ec.data});
        end
      end
      if (fail_valid) begin
        if (fail_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected fail pulse: got addr %0h syn %0h at cycle %0d, expected none", fail_addr, fail_syndrome, rel);
        end else begin
          ef = fail_q.pop_front();
          checkOutput("fail pulse {cycle,addr,syndrome}",
                      {32'(rel), 8'(fail_addr), fail_syndrome},
                      {32'(ef.cyc), 8'(ef.addr), ef.syn});
        end
      end
    end
  end

  initial begin
    int a, b;
    rst   = 1'b1;
    start = 1'b0;
    clear_faults();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset mem_en", 64'(mem_en), 64'd0);
    checkOutput("reset busy/done/pass", 64'({busy, done, pass}), 64'd0);
    checkOutput("reset fail_count", 64'(fail_count), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("idle busy", 64'(busy), 64'd0);

    $display("[TB] fault-free run");
    run_full("clean");

    $display("[TB] stuck-at-0 bit0 @7");
    clear_faults();
    sa0[7] = 8'h01;
    run_full("sa0_a7");
    checkOutput("sa0_a7 count", 64'(fail_count), 64'd2);

    $display("[TB] stuck-at-1 bit7 @1D");
    clear_faults();
    sa1[29] = 8'h80;
    run_full("sa1_a1d");
    checkOutput("sa1_a1d count", 64'(fail_count), 64'd3);

    $display("[TB] adjacent faults @3,@4");
    clear_faults();
    sa1[3] = 8'h01;
    sa1[4] = 8'h02;
    run_full("adjacent");

    $display("[TB] random fault runs");
    for (int r = 0; r < 3; r++) begin
      clear_faults();
      repeat ($urandom_range(1, 3)) begin
        a = int'($urandom_range(0, 31));
        b = int'($urandom_range(0, 7));
        if ($urandom_range(0, 1) == 1) begin
          sa1[a][b] = 1'b1;
          sa0[a][b] = 1'b0;
        end else begin
          sa0[a][b] = 1'b1;
          sa1[a][b] = 1'b0;
        end
      end
      run_full("random");
    end

    $display("[TB] start held high");
    clear_faults();
    sa1[5] = 8'h04;
    build_model();
    applyStimulus(1'b1);
    wait_rel(TOTAL + 1);
    checkOutput("hold busy in drain", 64'(busy), 64'd1);
    wait_rel(TOTAL + 2);
    checkOutput("hold done", 64'(done), 64'd1);
    checkOutput("hold first count", 64'(fail_count), 64'd3);
    build_model();
    @(posedge clk);
    #1;
    start_edge = edge_cnt;
    checkOutput("hold restart busy", 64'(busy), 64'd1);
    checkOutput("hold restart done", 64'(done), 64'd0);
    checkOutput("hold restart count cleared", 64'(fail_count), 64'd0);
    start = 1'b0;
    wait_rel(TOTAL + 2);
    checkOutput("hold second done", 64'(done), 64'd1);
    checkOutput("hold second count", 64'(fail_count), 64'd3);
    checkOutput("hold leftover expectations", 64'(cmd_q.size() + fail_q.size()), 64'd0);

    $display("[TB] reset mid-run");
    clear_faults();
    sa0[29] = 8'h08;
    build_model();
    applyStimulus(1'b0);
    wait_rel(150);
    rst = 1'b1;
    #1;
    cmd_q.delete();
    fail_q.delete();
    checkOutput("midrst mem_en/we", 64'({mem_en, mem_we}), 64'd0);
    checkOutput("midrst mem_addr/wdata", 64'({mem_addr, mem_wdata}), 64'd0);
    checkOutput("midrst fail_valid", 64'(fail_valid), 64'd0);
    checkOutput("midrst fail_addr/syn", 64'({fail_addr, fail_syndrome}), 64'd0);
    checkOutput("midrst fail_count", 64'(fail_count), 64'd0);
    checkOutput("midrst busy/done/pass", 64'({busy, done, pass}), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("postrst fail_valid", 64'(fail_valid), 64'd0);
    checkOutput("postrst busy", 64'(busy), 64'd0);
    run_full("after_reset");
    checkOutput("after_reset count", 64'(fail_count), 64'd2);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
